// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock setting path: FSM states, edit
// targets, field codes, BCD limits and a BCD range check.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_HH,
        ST_EDIT_MM,
        ST_EDIT_SS,
        ST_EDIT_PM,
        ST_COMMIT
    } state_t;

    typedef enum logic {
        TGT_TIME,
        TGT_ALARM
    } target_t;

    localparam logic [1:0] FLD_HH = 2'd0;
    localparam logic [1:0] FLD_MM = 2'd1;
    localparam logic [1:0] FLD_SS = 2'd2;
    localparam logic [1:0] FLD_PM = 2'd3;

    localparam logic [7:0] HH_MIN   = 8'h01;
    localparam logic [7:0] HH_MAX   = 8'h12;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] RESET_HH = 8'h12;

    // Both digits decimal and the value inside the field's legal range.
    // Plain byte compares are safe once both digits are known to be 0..9.
    function automatic logic bcd_valid(input logic [7:0] v, input logic is_hour);
        logic digits_ok;
        digits_ok = (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
        if (is_hour)
            return digits_ok && (v >= HH_MIN) && (v <= HH_MAX);
        else
            return digits_ok && (v <= MS_MAX);
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One-step BCD increment/decrement with field wrap. Hours run 01..12,
// minutes/seconds 00..59. Invalid input snaps to the field minimum on any
// step; up and down together leave the value untouched.
module bcd_field_step
    import clock_pkg::*;
(
    input  logic [7:0] value,
    input  logic       up,
    input  logic       down,
    input  logic       is_hour,
    output logic [7:0] stepped
);

    // Stepped value, with wrap at the field limits and per-digit BCD carry.
    always_comb begin
        stepped = value;
        if (up ^ down) begin
            if (!bcd_valid(value, is_hour)) begin
                stepped = is_hour ? HH_MIN : MS_MIN;
            end else if (up) begin
                if (is_hour && value == HH_MAX)
                    stepped = HH_MIN;
                else if (!is_hour && value == MS_MAX)
                    stepped = MS_MIN;
                else if (value[3:0] == 4'h9)
                    stepped = {value[7:4] + 4'h1, 4'h0};
                else
                    stepped = {value[7:4], value[3:0] + 4'h1};
            end else begin
                if (is_hour && value == HH_MIN)
                    stepped = HH_MAX;
                else if (!is_hour && value == MS_MIN)
                    stepped = MS_MAX;
                else if (value[3:0] == 4'h0)
                    stepped = {value[7:4] - 4'h1, 4'h9};
                else
                    stepped = {value[7:4], value[3:0] - 4'h1};
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller. Edits a shadow copy of hh:mm:ss + PM one
// field at a time from single-cycle button pulses, then issues a one-cycle
// load strobe to the clock core (time) or the alarm registers.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for set_req / alarm_req, no strobe
//   ST_EDIT_HH | editing hours (01..12)
//   ST_EDIT_MM | editing minutes (00..59)
//   ST_EDIT_SS | editing seconds (00..59)
//   ST_EDIT_PM | editing PM flag (toggle)
//   ST_COMMIT  | one cycle, load_time or load_alarm high, then idle
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       set_req,
    input  logic       alarm_req,
    input  logic       next,
    input  logic       inc,
    input  logic       dec,
    input  logic       cancel,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    input  logic       cur_pm,
    output logic [7:0] hh_load,
    output logic [7:0] mm_load,
    output logic [7:0] ss_load,
    output logic       pm_load,
    output logic       load_time,
    output logic       load_alarm,
    output logic       editing,
    output logic [1:0] field
);

    // Abort fires when the count of earlier quiet cycles reaches this value,
    // i.e. on the TIMEOUT_S-th consecutive quiet cycle itself.
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

    state_t     state;
    target_t    target;
    logic [5:0] tmo_cnt;
    logic [7:0] step_in;
    logic [7:0] step_out;
    logic       step_hour;

    // Route the field being edited into the shared stepper.
    always_comb begin
        step_in   = hh_load;
        step_hour = 1'b0;
        case (state)
            ST_EDIT_HH: begin
                step_in   = hh_load;
                step_hour = 1'b1;
            end
            ST_EDIT_MM: step_in = mm_load;
            ST_EDIT_SS: step_in = ss_load;
            default: ;
        endcase
    end

    bcd_field_step u_step (
        .value   (step_in),
        .up      (inc),
        .down    (dec),
        .is_hour (step_hour),
        .stepped (step_out)
    );

    // Edit FSM with shadow registers, timeout counter and registered outputs.
    always_ff @(posedge clk_1s) begin
        if (reset) begin
            state      <= ST_IDLE;
            target     <= TGT_TIME;
            tmo_cnt    <= 6'd0;
            hh_load    <= RESET_HH;
            mm_load    <= MS_MIN;
            ss_load    <= MS_MIN;
            pm_load    <= 1'b0;
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
            editing    <= 1'b0;
            field      <= FLD_HH;
        end else begin
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= 6'd0;
                    if (set_req) begin
                        hh_load <= cur_hh;
                        mm_load <= cur_mm;
                        ss_load <= cur_ss;
                        pm_load <= cur_pm;
                        target  <= TGT_TIME;
                        state   <= ST_EDIT_HH;
                        editing <= 1'b1;
                        field   <= FLD_HH;
                    end else if (alarm_req) begin
                        hh_load <= RESET_HH;
                        mm_load <= MS_MIN;
                        ss_load <= MS_MIN;
                        pm_load <= 1'b0;
                        target  <= TGT_ALARM;
                        state   <= ST_EDIT_HH;
                        editing <= 1'b1;
                        field   <= FLD_HH;
                    end
                end

                ST_EDIT_HH, ST_EDIT_MM, ST_EDIT_SS, ST_EDIT_PM: begin
                    if (cancel) begin
                        state   <= ST_IDLE;
                        editing <= 1'b0;
                        field   <= FLD_HH;
                        tmo_cnt <= 6'd0;
                    end else if (next || inc || dec) begin
                        tmo_cnt <= 6'd0;
                        // The step lands first; an accompanying next then
                        // moves on with the already-stepped value.
                        case (state)
                            ST_EDIT_HH: hh_load <= step_out;
                            ST_EDIT_MM: mm_load <= step_out;
                            ST_EDIT_SS: ss_load <= step_out;
                            ST_EDIT_PM: if (inc ^ dec) pm_load <= ~pm_load;
                            default: ;
                        endcase
                        if (next) begin
                            case (state)
                                ST_EDIT_HH: begin
                                    state <= ST_EDIT_MM;
                                    field <= FLD_MM;
                                end
                                ST_EDIT_MM: begin
                                    state <= ST_EDIT_SS;
                                    field <= FLD_SS;
                                end
                                ST_EDIT_SS: begin
                                    state <= ST_EDIT_PM;
                                    field <= FLD_PM;
                                end
                                ST_EDIT_PM: begin
                                    state      <= ST_COMMIT;
                                    editing    <= 1'b0;
                                    field      <= FLD_HH;
                                    load_time  <= (target == TGT_TIME);
                                    load_alarm <= (target == TGT_ALARM);
                                end
                                default: ;
                            endcase
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        state   <= ST_IDLE;
                        editing <= 1'b0;
                        field   <= FLD_HH;
                        tmo_cnt <= 6'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 6'd1;
                    end
                end

                ST_COMMIT: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences, a decimal-arithmetic
// model compared against every output on every cycle, and literal spot
// checks at the interesting points of each sequence.
module tb_time_set_ctrl;

    localparam int TO = 3;

    localparam logic [5:0] B_SET = 6'b100000;
    localparam logic [5:0] B_ALR = 6'b010000;
    localparam logic [5:0] B_NXT = 6'b001000;
    localparam logic [5:0] B_INC = 6'b000100;
    localparam logic [5:0] B_DEC = 6'b000010;
    localparam logic [5:0] B_CAN = 6'b000001;
    localparam logic [5:0] B_NONE = 6'b000000;

    logic       clk_1s = 1'b0;
    logic       reset = 1'b1;
    logic       set_req = 1'b0, alarm_req = 1'b0, next = 1'b0;
    logic       inc = 1'b0, dec = 1'b0, cancel = 1'b0;
    logic [7:0] cur_hh = 8'h00, cur_mm = 8'h00, cur_ss = 8'h00;
    logic       cur_pm = 1'b0;
    logic [7:0] hh_load, mm_load, ss_load;
    logic       pm_load, load_time, load_alarm, editing;
    logic [1:0] field;

    int checks = 0;
    int errors = 0;

    time_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk_1s     (clk_1s),
        .reset      (reset),
        .set_req    (set_req),
        .alarm_req  (alarm_req),
        .next       (next),
        .inc        (inc),
        .dec        (dec),
        .cancel     (cancel),
        .cur_hh     (cur_hh),
        .cur_mm     (cur_mm),
        .cur_ss     (cur_ss),
        .cur_pm     (cur_pm),
        .hh_load    (hh_load),
        .mm_load    (mm_load),
        .ss_load    (ss_load),
        .pm_load    (pm_load),
        .load_time  (load_time),
        .load_alarm (load_alarm),
        .editing    (editing),
        .field      (field)
    );

    always #5 clk_1s = ~clk_1s;

    // phase: 0 idle, 1 editing, 2 commit cycle
    typedef struct {
        int         phase;
        int         fld;
        bit         alarm;
        int         quiet;
        logic [7:0] hh, mm, ss;
        bit         pm;
    } mdl_t;

    mdl_t m;
    bit   m_valid = 1'b0;

    // Decode to a decimal number, step with modulo arithmetic, re-encode.
    function automatic logic [7:0] bstep(logic [7:0] v, bit up, bit hour);
        int hi, lo, n;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        n  = hi * 10 + lo;
        if (hi > 9 || lo > 9 || (hour ? (n < 1 || n > 12) : (n > 59)))
            n = hour ? 1 : 0;
        else if (hour)
            n = up ? (n % 12) + 1 : ((n + 10) % 12) + 1;
        else
            n = up ? (n + 1) % 60 : (n + 59) % 60;
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic mdl_t mnext(mdl_t s, bit rst, bit st, bit al, bit nx,
                                   bit in_, bit de, bit ca);
        mdl_t n;
        n = s;
        if (rst) begin
            n.phase = 0; n.fld = 0; n.alarm = 0; n.quiet = 0;
            n.hh = 8'h12; n.mm = 8'h00; n.ss = 8'h00; n.pm = 0;
            return n;
        end
        if (s.phase == 2) begin
            n.phase = 0;
        end else if (s.phase == 0) begin
            if (st) begin
                n.hh = cur_hh; n.mm = cur_mm; n.ss = cur_ss; n.pm = cur_pm;
                n.alarm = 0; n.phase = 1; n.fld = 0; n.quiet = 0;
            end else if (al) begin
                n.hh = 8'h12; n.mm = 8'h00; n.ss = 8'h00; n.pm = 0;
                n.alarm = 1; n.phase = 1; n.fld = 0; n.quiet = 0;
            end
        end else begin
            if (ca) begin
                n.phase = 0;
            end else if (nx || in_ || de) begin
                n.quiet = 0;
                if (in_ != de) begin
                    case (s.fld)
                        0: n.hh = bstep(s.hh, in_, 1);
                        1: n.mm = bstep(s.mm, in_, 0);
                        2: n.ss = bstep(s.ss, in_, 0);
                        default: n.pm = !s.pm;
                    endcase
                end
                if (nx) begin
                    if (s.fld == 3) n.phase = 2;
                    else n.fld = s.fld + 1;
                end
            end else begin
                n.quiet = s.quiet + 1;
                if (n.quiet >= TO) n.phase = 0;
            end
        end
        return n;
    endfunction

    // Model advances on the same edge as the DUT, from the bench's inputs only.
    always @(posedge clk_1s) begin
        m <= mnext(m, reset, set_req, alarm_req, next, inc, dec, cancel);
        m_valid <= 1'b1;
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [5:0] b);
        @(negedge clk_1s);
        {set_req, alarm_req, next, inc, dec, cancel} = b;
    endtask

    task automatic set_cur(logic [7:0] h, logic [7:0] mi, logic [7:0] s, logic p);
        cur_hh = h; cur_mm = mi; cur_ss = s; cur_pm = p;
    endtask

    initial begin
        fork
            begin : compare_proc
                forever begin
                    @(negedge clk_1s);
                    if (m_valid) begin
                        chk("mdl_hh", hh_load, m.hh);
                        chk("mdl_mm", mm_load, m.mm);
                        chk("mdl_ss", ss_load, m.ss);
                        chk("mdl_pm", 8'(pm_load), 8'(m.pm));
                        chk("mdl_editing", 8'(editing), 8'(m.phase == 1));
                        chk("mdl_field", 8'(field), (m.phase == 1) ? 8'(m.fld) : 8'd0);
                        chk("mdl_load_time", 8'(load_time), 8'(m.phase == 2 && !m.alarm));
                        chk("mdl_load_alarm", 8'(load_alarm), 8'(m.phase == 2 && m.alarm));
                    end
                end
            end
            begin : stimulus
                drive(B_NONE);
                drive(B_NONE);
                reset = 1'b0;
                chk("rst_hh", hh_load, 8'h12);
                chk("rst_mm", mm_load, 8'h00);
                chk("rst_editing", 8'(editing), 8'd0);
                chk("rst_strobes", 8'({load_time, load_alarm}), 8'd0);

                // set time from 11:59:58 PM, hour up, commit
                set_cur(8'h11, 8'h59, 8'h58, 1'b1);
                drive(B_SET);
                drive(B_INC);
                chk("set_seed_field", 8'(field), 8'd0);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_NONE);
                chk("set_load_time", 8'(load_time), 8'd1);
                chk("set_load_alarm", 8'(load_alarm), 8'd0);
                chk("set_hh", hh_load, 8'h12);
                chk("set_mm", mm_load, 8'h59);
                chk("set_ss", ss_load, 8'h58);
                chk("set_pm", 8'(pm_load), 8'd1);
                drive(B_NONE);
                chk("set_strobe_1cyc", 8'(load_time), 8'd0);

                // alarm edit with downward wraps
                drive(B_ALR);
                drive(B_DEC);
                drive(B_NXT);
                drive(B_DEC);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_INC);
                drive(B_NXT);
                drive(B_NONE);
                chk("alm_load_alarm", 8'(load_alarm), 8'd1);
                chk("alm_load_time", 8'(load_time), 8'd0);
                chk("alm_hh", hh_load, 8'h11);
                chk("alm_mm", mm_load, 8'h59);
                chk("alm_ss", ss_load, 8'h00);
                chk("alm_pm", 8'(pm_load), 8'd1);

                // BCD boundaries, inc+dec together, cancel
                set_cur(8'h12, 8'h09, 8'h59, 1'b0);
                drive(B_SET);
                drive(B_INC);
                drive(B_DEC);
                chk("bnd_hh_inc_wrap", hh_load, 8'h01);
                drive(B_NXT);
                chk("bnd_hh_dec_wrap", hh_load, 8'h12);
                drive(B_INC);
                drive(B_NXT);
                chk("bnd_mm_carry", mm_load, 8'h10);
                drive(B_INC);
                drive(B_INC | B_DEC);
                chk("bnd_ss_wrap", ss_load, 8'h00);
                drive(B_CAN);
                chk("bnd_incdec_nochg", ss_load, 8'h00);
                drive(B_NONE);
                chk("cancel_editing", 8'(editing), 8'd0);
                chk("cancel_no_strobe", 8'({load_time, load_alarm}), 8'd0);

                // timeout after 3 quiet cycles
                drive(B_ALR);
                drive(B_NONE);
                drive(B_NONE);
                drive(B_NONE);
                chk("tmo_3rd_cycle_editing", 8'(editing), 8'd1);
                drive(B_NONE);
                chk("tmo_aborted", 8'(editing), 8'd0);
                chk("tmo_no_strobe", 8'({load_time, load_alarm}), 8'd0);

                // set wins over alarm, alarm during edit ignored, reset in commit
                set_cur(8'h03, 8'h04, 8'h05, 1'b0);
                drive(B_SET | B_ALR);
                drive(B_ALR);
                chk("prio_seed_time", hh_load, 8'h03);
                drive(B_NXT);
                chk("prio_alarm_ignored", mm_load, 8'h04);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_NXT);
                drive(B_NONE);
                chk("prio_target_time", 8'(load_time), 8'd1);
                reset = 1'b1;
                drive(B_NONE);
                reset = 1'b0;
                chk("rst_commit_strobe", 8'(load_time), 8'd0);
                chk("rst_commit_hh", hh_load, 8'h12);
                chk("rst_commit_mm", mm_load, 8'h00);

                // invalid minute seed snaps to 00
                set_cur(8'h05, 8'h7A, 8'h30, 1'b1);
                drive(B_SET);
                drive(B_NXT);
                drive(B_INC);
                drive(B_NONE);
                chk("inv_seed_mm", mm_load, 8'h00);
                drive(B_CAN);
                drive(B_NONE);
                drive(B_NONE);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
